// File: rtl/uart_mem_pkg.sv
// Shared encodings and packet helpers for the UART memory-channel arbiter.
package uart_mem_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND_HDR  = 3'd1;
  localparam logic [2:0] ST_SEND_ADDR = 3'd2;
  localparam logic [2:0] ST_SEND_DATA = 3'd3;
  localparam logic [2:0] ST_RECV      = 3'd4;
  localparam logic [2:0] ST_RESP      = 3'd5;

  // Header byte layout: {write, 3'b000, mask}
  localparam int HDR_WRITE_BIT = 7;
  localparam int HDR_MASK_MSB  = 3;

  localparam int PKT_ADDR_BYTES = 4;
  localparam int PKT_DATA_BYTES = 4;

  function automatic logic [7:0] make_hdr(input logic wr, input logic [3:0] mask);
    logic [7:0] h;
    h                  = 8'h00;
    h[HDR_WRITE_BIT]   = wr;
    h[HDR_MASK_MSB:0]  = mask;
    return h;
  endfunction

  // Little-endian byte pick from a 32-bit word
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_mem_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; grant is one-hot, state advances on en.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant_q, last_grant_d;

  // Pick the lone requester, or on a tie the port not granted last
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    last_grant_d = (en && (gnt != 2'b00)) ? gnt[1] : last_grant_q;
  end

  // Resets to 1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/uart_mem_arbiter.sv
// Shares one UART byte channel between two memory ports: packetises a request,
// collects the 4-byte read reply, and returns one response to the requester.
module uart_mem_arbiter
  import uart_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [7:0]          req_mask,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [63:0]         req_data,
  output logic [1:0]          resp_valid,
  output logic [31:0]         resp_data,
  output logic                send_flag,
  output logic [7:0]          send_data,
  input  logic                sendable,
  output logic                recv_flag,
  input  logic [7:0]          recv_data,
  input  logic                receivable
);

  localparam logic [1:0] ADDR_LAST = 2'(PKT_ADDR_BYTES - 1);
  localparam logic [1:0] DATA_LAST = 2'(PKT_DATA_BYTES - 1);

  logic [2:0]        state_q, state_d;
  logic              port_q, port_d;
  logic              write_q, write_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [1:0] gnt;
  logic       arb_en;
  logic       win;

  assign arb_en = (state_q == ST_IDLE) && (req_valid != 2'b00);
  assign win    = gnt[1];

  rr_arb2 u_arb (
    .clk (CLK),
    .rst (RST),
    .en  (arb_en),
    .req (req_valid),
    .gnt (gnt)
  );

  // Next-state, byte counter, reply shift register and all channel strobes
  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    write_d    = write_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    resp_data  = 32'h0;
    send_flag  = 1'b0;
    send_data  = 8'h00;
    recv_flag  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = gnt;
        if (arb_en) begin
          port_d  = win;
          write_d = req_write[win];
          mask_d  = win ? req_mask[7:4] : req_mask[3:0];
          addr_d  = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          data_d  = win ? req_data[63:32] : req_data[31:0];
          cnt_d   = 2'd0;
          state_d = ST_SEND_HDR;
        end
      end
      ST_SEND_HDR: begin
        send_flag = sendable;
        send_data = make_hdr(write_q, mask_q);
        if (sendable) state_d = ST_SEND_ADDR;
      end
      ST_SEND_ADDR: begin
        send_flag = sendable;
        send_data = get_byte(addr_q, cnt_q);
        if (sendable) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == ADDR_LAST) state_d = write_q ? ST_SEND_DATA : ST_RECV;
        end
      end
      ST_SEND_DATA: begin
        send_flag = sendable;
        send_data = get_byte(data_q, cnt_q);
        if (sendable) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == DATA_LAST) state_d = ST_RESP;
        end
      end
      ST_RECV: begin
        recv_flag = receivable;
        if (receivable) begin
          // first byte received ends up in [7:0] after four shifts
          rdata_d = {recv_data, rdata_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = port_q ? 2'b10 : 2'b01;
        resp_data  = write_q ? 32'h0 : rdata_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transaction registers; reset abandons any packet in progress
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      port_q  <= 1'b0;
      write_q <= 1'b0;
      mask_q  <= 4'h0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      cnt_q   <= 2'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      write_q <= write_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed bench: table of single transactions plus tie, back-pressure and
// mid-transaction reset sequences against a small UART FIFO model.
module tb_uart_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  req_valid, req_ready, req_write, resp_valid;
  logic [7:0]  req_mask, send_data, recv_data;
  logic [63:0] req_addr, req_data;
  logic [31:0] resp_data;
  logic        send_flag, sendable, recv_flag, receivable;

  uart_mem_arbiter #(.ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_mask(req_mask), .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .send_flag(send_flag), .send_data(send_data), .sendable(sendable),
    .recv_flag(recv_flag), .recv_data(recv_data), .receivable(receivable)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic             write;
    logic             port;
    logic [3:0]       mask;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [31:0]      rx;
    logic [3:0]       nbytes;
    logic [0:8][7:0]  exp_b;
    logic [31:0]      exp_rsp;
  } vec_t;

  vec_t vecs [4];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  int          hs_port_q[$], hs_cyc_q[$];
  int          rsp_port_q[$], rsp_cyc_q[$];
  logic [31:0] rsp_data_q[$];
  logic [1:0]  rsp_vld_q[$];

  int tx_stall_at = 0, tx_stall_rem = 0;
  int rx_stall_at = 0, rx_stall_rem = 0;
  int rx_pops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive the UART model, sample outputs mid-cycle, step to next negedge
  task automatic cycle();
    logic rx_ok;
    if (tx_stall_rem > 0 && tx_q.size() == tx_stall_at) begin
      sendable = 1'b0;
      tx_stall_rem--;
    end else sendable = 1'b1;
    rx_ok = 1'b1;
    if (rx_stall_rem > 0 && rx_pops == rx_stall_at) begin
      rx_ok = 1'b0;
      rx_stall_rem--;
    end
    receivable = rx_ok && (rx_q.size() > 0);
    recv_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    #1;
    if (send_flag) tx_q.push_back(send_data);
    if (recv_flag) begin
      rx_q.delete(0);
      rx_pops++;
    end
    if (!RST && (req_ready & req_valid) != 2'b00) begin
      hs_port_q.push_back(int'(req_ready[1]));
      hs_cyc_q.push_back(cyc);
    end
    if (!RST && resp_valid != 2'b00) begin
      rsp_port_q.push_back(int'(resp_valid[1]));
      rsp_cyc_q.push_back(cyc);
      rsp_data_q.push_back(resp_data);
      rsp_vld_q.push_back(resp_valid);
    end
    @(negedge CLK);
    cyc++;
  endtask

  task automatic clear_logs();
    tx_q.delete();
    hs_port_q.delete(); hs_cyc_q.delete();
    rsp_port_q.delete(); rsp_cyc_q.delete(); rsp_data_q.delete(); rsp_vld_q.delete();
    rx_pops = 0;
  endtask

  // Present one request on port p (other lane holds junk) and run to its response
  task automatic run_txn(input int p, input logic wr, input logic [3:0] m,
                         input logic [31:0] a, input logic [31:0] d);
    int n;
    logic ok;
    req_write = 2'b00;
    req_mask  = 8'h5A;
    req_addr  = 64'hBAD0_BAD1_BAD2_BAD3;
    req_data  = 64'h5555_AAAA_5555_AAAA;
    req_write[p]         = wr;
    req_mask[4*p +: 4]   = m;
    req_addr[32*p +: 32] = a;
    req_data[32*p +: 32] = d;
    req_valid    = 2'b00;
    req_valid[p] = 1'b1;
    n = 0;
    while (hs_port_q.size() == 0 && n < 50) begin cycle(); n++; end
    ok = (hs_port_q.size() != 0);
    req_valid = 2'b00;
    if (!ok) check("handshake_timeout", 32'(ok), 32'd1);
    n = 0;
    while (rsp_port_q.size() == 0 && n < 300) begin cycle(); n++; end
    ok = (rsp_port_q.size() != 0);
    if (!ok) check("response_timeout", 32'(ok), 32'd1);
  endtask

  task automatic apply_vec(input vec_t v, input int exp_lat, input string tag);
    clear_logs();
    if (!v.write) for (int k = 0; k < 4; k++) rx_q.push_back(v.rx[8*k +: 8]);
    run_txn(int'(v.port), v.write, v.mask, v.addr, v.data);
    check({tag, "_nbytes"}, 32'(tx_q.size()), 32'(v.nbytes));
    for (int i = 0; i < int'(v.nbytes); i++)
      check($sformatf("%s_byte%0d", tag, i),
            (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF, {24'h0, v.exp_b[i]});
    check({tag, "_nresp"}, 32'(rsp_port_q.size()), 32'd1);
    if (rsp_port_q.size() > 0 && hs_cyc_q.size() > 0) begin
      check({tag, "_hs_port"}, 32'(hs_port_q[0]), 32'(v.port));
      check({tag, "_resp_valid"}, {30'h0, rsp_vld_q[0]}, v.port ? 32'd2 : 32'd1);
      check({tag, "_resp_data"}, rsp_data_q[0], v.exp_rsp);
      check({tag, "_latency"}, 32'(rsp_cyc_q[0] - hs_cyc_q[0]), 32'(exp_lat));
    end
    check({tag, "_rx_left"}, 32'(rx_q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc_rel;
    vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_1004, 32'h0, 32'h1234_5678, 4'd5,
                {8'h0F, 8'h04, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0, 4'd9,
                {8'h83, 8'h00, 8'h02, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 4'h5, 32'hA1B2_C3D4, 32'h0, 32'hCAFE_F00D, 4'd5,
                {8'h05, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00}, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'h0102_0304, 32'h0, 4'd9,
                {8'h80, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04, 8'h03, 8'h02, 8'h01}, 32'h0};

    RST = 1'b1; req_valid = 2'b00; req_write = 2'b00; req_mask = 8'h0;
    req_addr = 64'h0; req_data = 64'h0; sendable = 1'b1; receivable = 1'b0; recv_data = 8'h0;
    @(negedge CLK);
    cycle(); cycle();
    RST = 1'b0;
    #1;
    check("rst_req_ready",  {30'h0, req_ready},  32'h0);
    check("rst_resp_valid", {30'h0, resp_valid}, 32'h0);
    check("rst_send_flag",  {31'h0, send_flag},  32'h0);
    check("rst_recv_flag",  {31'h0, recv_flag},  32'h0);
    check("rst_send_data",  {24'h0, send_data},  32'h0);
    check("rst_resp_data",  resp_data,           32'h0);

    // Table of single transactions, no back-pressure
    for (int v = 0; v < 4; v++) apply_vec(vecs[v], 10, $sformatf("vec%0d", v));

    // Back-pressure: send stall after header+2 addr bytes, receive stall after 2 pops
    tx_stall_at = 3; tx_stall_rem = 5;
    rx_stall_at = 2; rx_stall_rem = 7;
    apply_vec(vecs[0], 22, "bp");
    check("bp_tx_stall_used", 32'(tx_stall_rem), 32'd0);
    check("bp_rx_stall_used", 32'(rx_stall_rem), 32'd0);

    // Tie from reset, held for three grants
    RST = 1'b1; cycle(); RST = 1'b0;
    clear_logs();
    req_write = 2'b11; req_mask = 8'hFF;
    req_addr = 64'h0000_0020_0000_0010; req_data = 64'h2222_2222_1111_1111;
    req_valid = 2'b11;
    n = 0;
    while (rsp_port_q.size() < 3 && n < 200) begin cycle(); n++; end
    req_valid = 2'b00;
    check("tie_nresp", 32'(rsp_port_q.size()), 32'd3);
    if (rsp_port_q.size() >= 3 && hs_port_q.size() >= 3) begin
      check("tie_grant0", 32'(hs_port_q[0]), 32'd0);
      check("tie_grant1", 32'(hs_port_q[1]), 32'd1);
      check("tie_grant2", 32'(hs_port_q[2]), 32'd0);
      check("tie_resp0",  32'(rsp_port_q[0]), 32'd0);
      check("tie_resp1",  32'(rsp_port_q[1]), 32'd1);
      check("tie_resp2",  32'(rsp_port_q[2]), 32'd0);
      check("tie_gap01",  32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd11);
      check("tie_gap12",  32'(hs_cyc_q[2] - hs_cyc_q[1]), 32'd11);
      check("tie_wdata",  rsp_data_q[1], 32'h0);
    end

    // Reset while in the address phase of a port-0 write
    clear_logs();
    req_write = 2'b01; req_mask = 8'h0F; req_addr = 64'h0000_0000_1111_2222;
    req_data = 64'h0; req_valid = 2'b01;
    n = 0;
    while (hs_port_q.size() == 0 && n < 50) begin cycle(); n++; end
    req_valid = 2'b00;
    n = 0;
    while (tx_q.size() < 3 && n < 50) begin cycle(); n++; end
    check("rm_bytes_before", 32'(tx_q.size()), 32'd3);
    RST = 1'b1; cycle(); RST = 1'b0;
    #1;
    check("rm_send_flag",  {31'h0, send_flag},  32'h0);
    check("rm_recv_flag",  {31'h0, recv_flag},  32'h0);
    check("rm_resp_valid", {30'h0, resp_valid}, 32'h0);
    check("rm_send_data",  {24'h0, send_data},  32'h0);
    check("rm_resp_data",  resp_data,           32'h0);
    cyc_rel = cyc;
    apply_vec(vecs[2], 10, "rm_read");
    if (hs_cyc_q.size() > 0) check("rm_hs_immediate", 32'(hs_cyc_q[0]), 32'(cyc_rel));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
